// File: rtl/ga_pkg.sv
// Shared types and constants for the genetic-algorithm engine.
package ga_pkg;

    typedef enum logic [3:0] {
        IDLE, INIT_GEN, EVAL_REQ, EVAL_WAIT, GEN_END,
        SEL_A, SEL_B, XOVER, MUTATE, DONE
    } ga_state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Most-negative two's-complement value of a w-bit field, in the low w bits.
    function automatic logic [63:0] fit_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/ga_engine_if.sv
// Fitness-evaluator handshake: one request channel, one single-cycle response.
interface ga_engine_if #(
    parameter int unsigned CHROM_W = 32,
    parameter int unsigned FIT_W   = 27
);
    logic               fit_req_valid;
    logic               fit_req_ready;
    logic [CHROM_W-1:0] fit_req_chrom;
    logic               fit_rsp_valid;
    logic [FIT_W-1:0]   fit_rsp_fit;

    modport master (
        output fit_req_valid, fit_req_chrom,
        input  fit_req_ready, fit_rsp_valid, fit_rsp_fit
    );

    modport slave (
        input  fit_req_valid, fit_req_chrom,
        output fit_req_ready, fit_rsp_valid, fit_rsp_fit
    );
endinterface

// File: rtl/ga_lfsr32.sv
// 32-bit right-shifting Galois LFSR; a zero seed is replaced by 1 so it never locks up.
module ga_lfsr32
    import ga_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] seed,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= '0;
        else if (load)
            q <= (seed == '0) ? 32'h1 : seed;
        else if (en)
            q <= {1'b0, q[31:1]} ^ (q[0] ? LFSR_TAPS : '0);
    end

endmodule

// File: rtl/ga_engine.sv
// Generational GA core: random initial population, tournament selection, one-point
// crossover, mutation and elitist replacement, with fitness evaluated off-block.
module ga_engine
    import ga_pkg::*;
#(
    parameter int unsigned CHROM_W    = 32,
    parameter int unsigned FIT_W      = 27,
    parameter int unsigned POP_SIZE   = 16,
    parameter int unsigned MAX_GEN    = 100,
    parameter int unsigned MUT_THRESH = 8,
    localparam int unsigned GEN_W     = (MAX_GEN > 0) ? $clog2(MAX_GEN + 1) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        seed,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [GEN_W-1:0]   generation,
    output logic [CHROM_W-1:0] best,
    output logic [FIT_W-1:0]   best_fit,
    ga_engine_if.master        fit
);

    localparam int unsigned IDX_W = $clog2(POP_SIZE);
    localparam int unsigned ENT_W = CHROM_W + FIT_W;
    localparam logic [FIT_W-1:0] FIT_MIN = FIT_W'(fit_min(FIT_W));

    ga_state_t          state;
    logic [31:0]        rng;
    logic               init_gen;
    logic               cur_sel;
    logic [IDX_W-1:0]   idx;
    logic [CHROM_W-1:0] cand, pa, pb;
    logic [ENT_W-1:0]   bank [2][POP_SIZE];

    logic               start_ok;
    logic [GEN_W-1:0]   gen_next;
    logic               last_gen;

    assign start_ok      = start && (state == IDLE || state == DONE);
    assign gen_next      = init_gen ? generation : generation + 1'b1;
    assign last_gen      = (gen_next == GEN_W'(MAX_GEN));
    assign fit.fit_req_chrom = cand;

    ga_lfsr32 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start_ok),
        .en      (busy),
        .seed    (seed),
        .q       (rng)
    );

    // Tournament of two: low and high 16-bit rng fields pick the contestants.
    logic [IDX_W-1:0]   r1, r2;
    logic [ENT_W-1:0]   e1, e2;
    logic [CHROM_W-1:0] parent;

    assign r1 = rng[IDX_W-1:0];
    assign r2 = rng[16 +: IDX_W];
    assign e1 = bank[cur_sel][r1];
    assign e2 = bank[cur_sel][r2];
    assign parent = ($signed(e2[FIT_W-1:0]) > $signed(e1[FIT_W-1:0])) ?
                    e2[ENT_W-1:FIT_W] : e1[ENT_W-1:FIT_W];

    logic [31:0]        xpos, mpos;
    logic [CHROM_W-1:0] xmask, child, mutated;

    assign xpos = ({8'b0, rng[31:8]} % (CHROM_W - 1)) + 1;
    assign mpos = {8'b0, rng[31:8]} % CHROM_W;

    always_comb begin
        xmask   = {CHROM_W{1'b1}} << xpos;
        child   = (pa & xmask) | (pb & ~xmask);
        mutated = cand;
        if ({24'b0, rng[7:0]} < MUT_THRESH)
            mutated = cand ^ ({{(CHROM_W-1){1'b0}}, 1'b1} << mpos);
    end

    // Single write port: evaluated children go to nxt; at GEN_END the elite seeds the
    // bank that becomes nxt after the swap (the outgoing cur bank).
    logic               wr_en, wr_bank;
    logic [IDX_W-1:0]   wr_idx;
    logic [ENT_W-1:0]   wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_bank = ~cur_sel;
        wr_idx  = idx;
        wr_data = {cand, fit.fit_rsp_fit};
        if (state == EVAL_WAIT && fit.fit_rsp_valid) begin
            wr_en = 1'b1;
        end else if (state == GEN_END && !last_gen) begin
            wr_en   = 1'b1;
            wr_bank = cur_sel;
            wr_idx  = '0;
            wr_data = {best, best_fit};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            bank[wr_bank][wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            generation        <= '0;
            best              <= '0;
            best_fit          <= '0;
            fit.fit_req_valid <= 1'b0;
            init_gen          <= 1'b0;
            cur_sel           <= 1'b0;
            idx               <= '0;
            cand              <= '0;
            pa                <= '0;
            pb                <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state      <= INIT_GEN;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    generation <= '0;
                    idx        <= '0;
                    init_gen   <= 1'b1;
                    best       <= '0;
                    best_fit   <= FIT_MIN;
                end
                INIT_GEN: begin
                    cand              <= rng[CHROM_W-1:0];
                    fit.fit_req_valid <= 1'b1;
                    state             <= EVAL_REQ;
                end
                EVAL_REQ: if (fit.fit_req_ready) begin
                    fit.fit_req_valid <= 1'b0;
                    state             <= EVAL_WAIT;
                end
                EVAL_WAIT: if (fit.fit_rsp_valid) begin
                    if ($signed(fit.fit_rsp_fit) > $signed(best_fit)) begin
                        best     <= cand;
                        best_fit <= fit.fit_rsp_fit;
                    end
                    if (idx == IDX_W'(POP_SIZE - 1)) begin
                        state <= GEN_END;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= init_gen ? INIT_GEN : SEL_A;
                    end
                end
                GEN_END: begin
                    cur_sel    <= ~cur_sel;
                    init_gen   <= 1'b0;
                    generation <= gen_next;
                    if (last_gen) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx   <= IDX_W'(1);
                        state <= SEL_A;
                    end
                end
                SEL_A: begin
                    pa    <= parent;
                    state <= SEL_B;
                end
                SEL_B: begin
                    pb    <= parent;
                    state <= XOVER;
                end
                XOVER: begin
                    cand  <= child;
                    state <= MUTATE;
                end
                MUTATE: begin
                    cand              <= mutated;
                    fit.fit_req_valid <= 1'b1;
                    state             <= EVAL_REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ga_engine.sv
// Self-checking bench for ga_engine: two small instances driven by a directed sequence,
// request streams and results compared against a generation-level reference model.
module tb_ga_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] seed_a = '0, seed_b = '0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        busy_a, done_a, busy_b, done_b;
    logic [0:0]  gen_a;
    logic [3:0]  gen_b;
    logic [31:0] best_a, best_b;
    logic [26:0] bf_a, bf_b;

    ga_engine_if #(.CHROM_W(32), .FIT_W(27)) ia ();
    ga_engine_if #(.CHROM_W(32), .FIT_W(27)) ib ();

    ga_engine #(.CHROM_W(32), .FIT_W(27), .POP_SIZE(4), .MAX_GEN(0), .MUT_THRESH(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .seed(seed_a), .start(start_a), .busy(busy_a),
        .done(done_a), .generation(gen_a), .best(best_a), .best_fit(bf_a), .fit(ia)
    );

    ga_engine #(.CHROM_W(32), .FIT_W(27), .POP_SIZE(4), .MAX_GEN(10), .MUT_THRESH(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .seed(seed_b), .start(start_b), .busy(busy_b),
        .done(done_b), .generation(gen_b), .best(best_b), .best_fit(bf_b), .fit(ib)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    bit auto_a = 1'b0, pend_a = 1'b0, pend_b = 1'b0;
    logic [31:0] last_a, last_b;
    logic [31:0] got_a[$], got_b[$];
    bit mono_b, prev_ok_b;
    logic [26:0] prev_bf_b;

    logic [31:0] exp_q[$];
    logic [31:0] m_best;
    int          m_bf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] adv(input logic [31:0] x, input int n);
        for (int i = 0; i < n; i++)
            x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
        return x;
    endfunction

    // mode 0: popcount; mode 1: low 27 bits read as a signed number
    function automatic int fit_of(input logic [31:0] c, input bit mode);
        int f;
        if (!mode) return $countones(c);
        f = int'(c & 32'h07FF_FFFF);
        if (f >= (1 << 26)) f -= (1 << 27);
        return f;
    endfunction

    // Whole-run model for POP_SIZE=4, ready always high, response one cycle after acceptance.
    // The rng value seen by each decision is the seed advanced by the cycles elapsed so far.
    task automatic model_run(input logic [31:0] seed, input int maxgen, input bit mode);
        logic [31:0] r, pa, pb, child;
        logic [31:0] cc[4], nc[4];
        int          cf[4], nf[4];
        int          p, i1, i2;
        r = (seed == 0) ? 32'd1 : seed;
        exp_q.delete();
        m_best = '0;
        m_bf   = -(1 << 26);
        for (int i = 0; i < 4; i++) begin
            nc[i] = r;
            nf[i] = fit_of(r, mode);
            exp_q.push_back(r);
            if (nf[i] > m_bf) begin m_best = r; m_bf = nf[i]; end
            r = adv(r, 3);
        end
        r = adv(r, 1);
        for (int g = 1; g <= maxgen; g++) begin
            cc = nc; cf = nf;
            nc[0] = m_best; nf[0] = m_bf;
            for (int i = 1; i < 4; i++) begin
                i1 = int'((r & 32'hFFFF) % 4); i2 = int'((r >> 16) % 4);
                pa = (cf[i2] > cf[i1]) ? cc[i2] : cc[i1];
                r = adv(r, 1);
                i1 = int'((r & 32'hFFFF) % 4); i2 = int'((r >> 16) % 4);
                pb = (cf[i2] > cf[i1]) ? cc[i2] : cc[i1];
                r = adv(r, 1);
                p = int'((r >> 8) % 31) + 1;
                for (int b = 0; b < 32; b++) child[b] = (b < p) ? pb[b] : pa[b];
                r = adv(r, 1);
                if ((r & 32'hFF) < 8) child = child ^ (32'd1 << ((r >> 8) % 32));
                r = adv(r, 1);
                exp_q.push_back(child);
                nc[i] = child;
                nf[i] = fit_of(child, mode);
                if (nf[i] > m_bf) begin m_best = child; m_bf = nf[i]; end
                r = adv(r, 2);
            end
            r = adv(r, 1);
        end
    endtask

    // One clock of evaluator service, acting at the falling edge.
    task automatic step();
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        if (auto_a) begin
            ia.fit_rsp_valid = 1'b0;
            if (pend_a) begin
                ia.fit_rsp_valid = 1'b1;
                ia.fit_rsp_fit   = 27'(fit_of(last_a, 1'b0));
                pend_a = 1'b0;
            end
            if (ia.fit_req_valid && ia.fit_req_ready) begin
                pend_a = 1'b1; last_a = ia.fit_req_chrom; got_a.push_back(last_a);
            end
        end
        ib.fit_rsp_valid = 1'b0;
        if (pend_b) begin
            ib.fit_rsp_valid = 1'b1;
            ib.fit_rsp_fit   = 27'(fit_of(last_b, 1'b1));
            pend_b = 1'b0;
        end
        if (ib.fit_req_valid && ib.fit_req_ready) begin
            pend_b = 1'b1; last_b = ib.fit_req_chrom; got_b.push_back(last_b);
        end
        if (busy_b) begin
            if (prev_ok_b && ($signed(bf_b) < $signed(prev_bf_b))) mono_b = 1'b0;
            prev_bf_b = bf_b;
            prev_ok_b = 1'b1;
        end
    endtask

    task automatic run_until_done(input bit which, input int budget, input string tag);
        int n = 0;
        while (!(which ? done_b : done_a) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_finished_in_budget"}, 64'(n < budget), 64'd1);
    endtask

    task automatic compare_stream(input bit which, input string tag);
        int sz = which ? got_b.size() : got_a.size();
        check({tag, "_req_count"}, 64'(sz), 64'(exp_q.size()));
        for (int i = 0; i < sz && i < exp_q.size(); i++)
            check({tag, "_req"}, which ? got_b[i] : got_a[i], exp_q[i]);
    endtask

    task automatic start_b_run(input logic [31:0] s);
        seed_b = s;
        got_b.delete();
        mono_b = 1'b1;
        prev_ok_b = 1'b0;
        start_b = 1'b1;
        step();
    endtask

    logic [31:0] s;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ia.fit_req_ready = 1'b1; ia.fit_rsp_valid = 1'b0; ia.fit_rsp_fit = '0;
        ib.fit_req_ready = 1'b1; ib.fit_rsp_valid = 1'b0; ib.fit_rsp_fit = '0;
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_valid", ia.fit_req_valid, 0);
        check("rst_best", best_b, 0);
        check("rst_best_fit", bf_b, 0);
        check("rst_gen", gen_b, 0);
        reset_n = 1'b1;

        // Abort in EVAL_WAIT, then a late response must not restart anything
        auto_a = 1'b0;
        seed_a = $urandom | 32'h1;
        start_a = 1'b1;
        step();
        step();
        check("abort_req_valid", ia.fit_req_valid, 1);
        step();
        check("abort_wait_busy", busy_a, 1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_valid", ia.fit_req_valid, 0);
        check("abort_best", best_a, 0);
        check("abort_best_fit", bf_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ia.fit_rsp_valid = 1'b1;
        ia.fit_rsp_fit   = 27'h1;
        step();
        ia.fit_rsp_valid = 1'b0;
        step();
        check("late_rsp_busy", busy_a, 0);
        check("late_rsp_valid", ia.fit_req_valid, 0);
        check("late_rsp_best_fit", bf_a, 0);

        // Backpressure: request held stable, stray response ignored
        ia.fit_req_ready = 1'b0;
        seed_a = $urandom | 32'h1;
        start_a = 1'b1;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", ia.fit_req_valid, 1);
            check("stall_chrom", ia.fit_req_chrom, seed_a);
            if (i == 1) ia.fit_rsp_valid = 1'b1;
            if (i == 2) ia.fit_rsp_valid = 1'b0;
            step();
        end
        check("stall_valid_end", ia.fit_req_valid, 1);
        check("stall_busy_end", busy_a, 1);
        ia.fit_req_ready = 1'b1;
        got_a.delete();
        got_a.push_back(ia.fit_req_chrom);
        last_a = ia.fit_req_chrom;
        pend_a = 1'b1;
        auto_a = 1'b1;
        run_until_done(1'b0, 200, "stall_run");
        check("stall_run_reqs", 64'(got_a.size()), 4);

        // Initial population only, popcount fitness
        s = $urandom;
        seed_a = s;
        model_run(s, 0, 1'b0);
        got_a.delete();
        start_a = 1'b1;
        step();
        check("init_done_falls", done_a, 0);
        run_until_done(1'b0, 200, "init");
        compare_stream(1'b0, "init");
        check("init_gen", gen_a, 0);
        check("init_best", best_a, m_best);
        check("init_best_fit", bf_a, 64'(27'(m_bf)));
        check("init_busy", busy_a, 0);

        // Ten generations, signed low-27-bit fitness
        s = $urandom;
        model_run(s, 10, 1'b1);
        start_b_run(s);
        run_until_done(1'b1, 1000, "evo");
        compare_stream(1'b1, "evo");
        check("evo_total_reqs", 64'(got_b.size()), 34);
        check("evo_gen", gen_b, 10);
        check("evo_best", best_b, m_best);
        check("evo_best_fit", bf_b, 64'(27'(m_bf)));
        check("evo_monotonic", mono_b, 1);

        // Seed 0 behaves as seed 1
        model_run(32'd1, 10, 1'b1);
        start_b_run(32'd1);
        run_until_done(1'b1, 1000, "seed1");
        compare_stream(1'b1, "seed1");
        check("seed1_best", best_b, m_best);
        start_b_run(32'd0);
        run_until_done(1'b1, 1000, "seed0");
        compare_stream(1'b1, "seed0");
        check("seed0_best", best_b, m_best);
        check("seed0_best_fit", bf_b, 64'(27'(m_bf)));

        // start while busy ignored; start in DONE restarts
        s = $urandom;
        model_run(s, 10, 1'b1);
        start_b_run(s);
        for (int i = 0; i < 40; i++) begin
            if (i == 20) start_b = 1'b1;
            step();
        end
        run_until_done(1'b1, 1000, "busy_start");
        compare_stream(1'b1, "busy_start");
        check("busy_start_best", best_b, m_best);
        check("restart_pre_done", done_b, 1);
        start_b_run(s);
        check("restart_done_falls", done_b, 0);
        check("restart_busy", busy_b, 1);
        check("restart_gen", gen_b, 0);
        run_until_done(1'b1, 1000, "restart");
        compare_stream(1'b1, "restart");
        check("restart_gen_end", gen_b, 10);
        check("restart_best_fit", bf_b, 64'(27'(m_bf)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
